// File: rtl/store_buffer_if.sv
// CPU-side and memory-side signal bundle for the store buffer.
interface store_buffer_if #(
  parameter int COUNT_W = 3
);
  logic               cpu_mem_read;
  logic               cpu_mem_write;
  logic [31:0]        cpu_address;
  logic [31:0]        cpu_write_data;
  logic [31:0]        cpu_read_data;
  logic               stall;
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_address;
  logic [31:0]        mem_write_data;
  logic [31:0]        mem_read_data;
  logic [COUNT_W-1:0] count;
  logic               empty;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_address, cpu_write_data, mem_read_data,
    output cpu_read_data, stall, mem_read, mem_write, mem_address, mem_write_data,
           count, empty
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_address, cpu_write_data, mem_read_data,
    input  cpu_read_data, stall, mem_read, mem_write, mem_address, mem_write_data,
           count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Circular write buffer between the MEM stage and data memory: drains one store
// per cycle when no load owns the port, and forwards buffered data to loads.
module store_buffer #(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 3
) (
  input  logic          clk,
  input  logic          rstn,
  store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]        addr_q [DEPTH];
  logic [31:0]        data_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               full;
  logic               accept;
  logic               drain;
  logic               hit;
  logic [31:0]        fwd_data;
  logic [PTR_W-1:0]   idx;

  logic               stall_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic [31:0]        mem_address_o;
  logic [31:0]        mem_write_data_o;
  logic [31:0]        cpu_read_data_o;

  assign full   = (count_q == COUNT_W'(DEPTH));
  assign drain  = rstn && (count_q != '0) && !bus.cpu_mem_read;
  assign accept = rstn && bus.cpu_mem_write && !full;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((i < 32'(count_q)) && (addr_q[idx] == bus.cpu_address)) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_comb begin
    stall_o          = 1'b0;
    mem_read_o       = 1'b0;
    mem_write_o      = 1'b0;
    mem_address_o    = '0;
    mem_write_data_o = '0;
    cpu_read_data_o  = '0;
    if (rstn) begin
      stall_o          = bus.cpu_mem_write && full;
      mem_read_o       = bus.cpu_mem_read;
      mem_write_o      = drain;
      mem_address_o    = drain ? addr_q[head_q] : bus.cpu_address;
      mem_write_data_o = drain ? data_q[head_q] : '0;
      if (bus.cpu_mem_read) begin
        cpu_read_data_o = hit ? fwd_data : bus.mem_read_data;
      end
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(drain);
    tail_d  = tail_q + PTR_W'(accept);
    count_d = count_q + COUNT_W'(accept) - COUNT_W'(drain);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail_q] <= bus.cpu_address;
      data_q[tail_q] <= bus.cpu_write_data;
    end
  end

  assign bus.stall          = stall_o;
  assign bus.mem_read       = mem_read_o;
  assign bus.mem_write      = mem_write_o;
  assign bus.mem_address    = mem_address_o;
  assign bus.mem_write_data = mem_write_data_o;
  assign bus.cpu_read_data  = cpu_read_data_o;
  assign bus.count          = count_q;
  assign bus.empty          = (count_q == '0);
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference predicts drains,
// load data and per-cycle flags; a negedge monitor pops and compares.
module tb_store_buffer;
  localparam int DEPTH   = 4;
  localparam int COUNT_W = 3;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          mr;
    bit          mw;
    int          cnt;
    logic [31:0] addr;
  } rec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rstn;

  store_buffer_if #(.COUNT_W(COUNT_W)) mif ();

  store_buffer #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (mif)
  );

  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];

  rec_t        cq[$];
  ent_t        dq[$];
  logic [31:0] lq[$];
  ent_t        ref_q[$];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mif.mem_read_data = dmem[mif.mem_address[9:2]];

  always @(posedge clk) begin
    if (mif.mem_write) dmem[mif.mem_address[9:2]] <= mif.mem_write_data;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs just after the edge and predict its outcome.
  task automatic step(input bit rst, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d);
    rec_t        r;
    ent_t        e;
    int          sz;
    logic [31:0] ld;
    @(posedge clk);
    #1;
    rstn               = !rst;
    mif.cpu_mem_read   = rd;
    mif.cpu_mem_write  = wr;
    mif.cpu_address    = a;
    mif.cpu_write_data = d;
    r = '{rst: rst, stall: 1'b0, mr: 1'b0, mw: 1'b0, cnt: 0, addr: a};
    if (rst) begin
      cq.push_back(r);
      ref_q.delete();
      return;
    end
    sz      = ref_q.size();
    r.cnt   = sz;
    r.stall = wr && (sz == DEPTH);
    r.mr    = rd;
    r.mw    = !rd && (sz > 0);
    if (rd) begin
      ld = ref_mem[a[9:2]];
      foreach (ref_q[k]) if (ref_q[k].a == a) ld = ref_q[k].d;
      lq.push_back(ld);
    end
    if (r.mw) begin
      e = ref_q.pop_front();
      ref_mem[e.a[9:2]] = e.d;
      dq.push_back(e);
    end
    if (wr && (sz < DEPTH)) ref_q.push_back('{a: a, d: d});
    cq.push_back(r);
  endtask

  initial begin : monitor
    rec_t r;
    ent_t e;
    logic [31:0] ld;
    forever begin
      @(negedge clk);
      if (cq.size() != 0) begin
        r = cq.pop_front();
        chk("stall", 32'(mif.stall), 32'(r.stall));
        chk("mem_read", 32'(mif.mem_read), 32'(r.mr));
        chk("mem_write", 32'(mif.mem_write), 32'(r.mw));
        if (r.rst) begin
          chk("rst_mem_address", mif.mem_address, 32'h0);
          chk("rst_mem_write_data", mif.mem_write_data, 32'h0);
          chk("rst_cpu_read_data", mif.cpu_read_data, 32'h0);
        end else begin
          chk("count", 32'(mif.count), 32'(r.cnt));
          chk("empty", 32'(mif.empty), 32'(r.cnt == 0));
          if (mif.mem_write) begin
            if (dq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_drain actual=%h expected=none", mif.mem_address);
            end else begin
              e = dq.pop_front();
              chk("drain_addr", mif.mem_address, e.a);
              chk("drain_data", mif.mem_write_data, e.d);
            end
          end else begin
            chk("idle_mem_address", mif.mem_address, r.addr);
            chk("idle_mem_write_data", mif.mem_write_data, 32'h0);
          end
          if (mif.mem_read) begin
            if (lq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_load actual=%h expected=none", mif.cpu_read_data);
            end else begin
              ld = lq.pop_front();
              chk("load_data", mif.cpu_read_data, ld);
            end
          end else begin
            chk("no_load_read_data", mif.cpu_read_data, 32'h0);
          end
        end
      end
    end
  end

  localparam logic [31:0] BASE = 32'h1000_8000;

  initial begin : stimulus
    logic [31:0] a;
    logic [31:0] d;
    int unsigned sel;
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    rstn = 1'b0;
    mif.cpu_mem_read   = 1'b0;
    mif.cpu_mem_write  = 1'b0;
    mif.cpu_address    = '0;
    mif.cpu_write_data = '0;

    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, BASE, 32'h0);

    // Reset mid-operation: buffered store is discarded, never reaches memory.
    step(0, 0, 1, BASE + 32'h40, 32'hAAAA_0001);
    step(1, 0, 0, BASE, 32'h0);
    step(0, 0, 0, BASE, 32'h0);
    step(0, 1, 0, BASE + 32'h40, 32'h0);

    // Single store, drain next cycle, readback from memory.
    step(0, 0, 1, BASE, 32'hDEAD_BEEF);
    step(0, 0, 0, BASE + 32'h8, 32'h0);
    step(0, 0, 0, BASE + 32'h8, 32'h0);
    step(0, 1, 0, BASE, 32'h0);

    // Forwarding: load sees the buffered value, then the younger one.
    step(0, 0, 1, BASE + 32'h4, 32'h1111_1111);
    step(0, 1, 0, BASE + 32'h4, 32'h0);
    step(0, 0, 1, BASE + 32'h4, 32'h2222_2222);
    step(0, 1, 0, BASE + 32'h4, 32'h0);
    step(0, 1, 0, BASE + 32'h4, 32'h0);
    // Full 32-bit compare: aliasing address must not forward.
    step(0, 1, 0, BASE + 32'h0001_0004, 32'h0);
    step(0, 0, 0, BASE, 32'h0);
    step(0, 1, 0, BASE + 32'h4, 32'h0);

    // Ten back-to-back stores: pointers wrap, drains in order.
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, BASE + 32'h80 + 32'(i * 4), 32'h5000_0000 + 32'(i * 32'h0101));
    step(0, 0, 0, BASE, 32'h0);
    step(0, 0, 0, BASE, 32'h0);
    for (int i = 0; i < 10; i++)
      step(0, 1, 0, BASE + 32'h80 + 32'(i * 4), 32'h0);

    // Randomized mix of loads, stores, idles and occasional resets.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 99);
      a   = BASE + {24'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 9) == 0) a = a | 32'h0001_0000;
      d   = $urandom;
      if (sel < 2)       step(1, 0, 0, a, d);
      else if (sel < 42) step(0, 1, 0, a, d);
      else if (sel < 82) step(0, 0, 1, a, d);
      else               step(0, 0, 0, a, d);
    end

    step(0, 0, 0, BASE, 32'h0);
    step(0, 0, 0, BASE, 32'h0);
    step(0, 0, 0, BASE, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("pending_drains", 32'(dq.size()), 32'h0);
    chk("pending_loads", 32'(lq.size()), 32'h0);
    chk("pending_cycles", 32'(cq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
